// File: rtl/ysyx_23060332_lsu.sv
// ysyx_23060332_lsu -- load/store unit, initiator side of the data-memory port.
//
// Accepts one load or store at a time from the EXU, issues a single word-aligned
// request to data memory (byte lanes via mem_wmask), and returns the
// sign/zero-extended load result, or an error, to write-back.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   lsu_valid/lsu_ready   EXU request handshake (ready only in IDLE)
//   lsu_wen/funct3/addr/wdata   request fields (store data unshifted)
//   mem_req_valid/ready   memory request handshake
//   mem_wen/addr/wdata/wmask    request fields (addr word aligned)
//   mem_rsp_valid/rdata   one-cycle response, read word
//   wb_valid/wb_ready     write-back handshake
//   wb_rdata/wb_err       extended load data (0 for stores/errors), error flag
module ysyx_23060332_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        lsu_valid,
  output logic        lsu_ready,
  input  logic        lsu_wen,
  input  logic [2:0]  lsu_funct3,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_rdata,
  output logic        wb_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        wen_q, wen_d;
  logic [2:0]  f3_q, f3_d;
  logic [1:0]  off_q, off_d;
  logic        req_valid_q, req_valid_d;
  logic        mwen_q, mwen_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [7:0]  mwmask_q, mwmask_d;
  logic        wb_valid_q, wb_valid_d;
  logic [31:0] wb_rdata_q, wb_rdata_d;
  logic        wb_err_q, wb_err_d;

  // Legal encoding and natural alignment; funct3[1:0] encodes the access size.
  function automatic logic req_ok(input logic wen, input logic [2:0] f3,
                                  input logic [1:0] a);
    logic enc_ok;
    logic mis;
    if (wen) enc_ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else     enc_ok = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
    mis = ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    return enc_ok && !mis;
  endfunction

  function automatic logic [7:0] store_mask(input logic [1:0] sz, input logic [1:0] off);
    case (sz)
      2'b00:   return 8'h01 << off;
      2'b01:   return 8'h03 << off;
      default: return 8'h0F;
    endcase
  endfunction

  // Data is replicated across lanes so the mask alone selects the target bytes.
  function automatic logic [31:0] store_data(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] off,
                                           input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{off, 3'b000} +: 8];
    h = off[1] ? rd[31:16] : rd[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b100:  return {24'd0, b};
      3'b101:  return {16'd0, h};
      default: return rd;
    endcase
  endfunction

  assign lsu_ready = (state_q == S_IDLE) && !rst;

  always_comb begin
    state_d     = state_q;
    wen_d       = wen_q;
    f3_d        = f3_q;
    off_d       = off_q;
    req_valid_d = req_valid_q;
    mwen_d      = mwen_q;
    maddr_d     = maddr_q;
    mwdata_d    = mwdata_q;
    mwmask_d    = mwmask_q;
    wb_valid_d  = wb_valid_q;
    wb_rdata_d  = wb_rdata_q;
    wb_err_d    = wb_err_q;
    case (state_q)
      S_IDLE: begin
        if (lsu_valid && lsu_ready) begin
          wen_d = lsu_wen;
          f3_d  = lsu_funct3;
          off_d = lsu_addr[1:0];
          if (req_ok(lsu_wen, lsu_funct3, lsu_addr[1:0])) begin
            req_valid_d = 1'b1;
            mwen_d      = lsu_wen;
            maddr_d     = {lsu_addr[31:2], 2'b00};
            mwmask_d    = lsu_wen ? store_mask(lsu_funct3[1:0], lsu_addr[1:0]) : 8'h00;
            mwdata_d    = lsu_wen ? store_data(lsu_funct3[1:0], lsu_wdata) : 32'd0;
            state_d     = S_REQ;
          end else begin
            // Rejected requests never touch memory.
            wb_valid_d = 1'b1;
            wb_err_d   = 1'b1;
            wb_rdata_d = 32'd0;
            state_d    = S_DONE;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) begin
          req_valid_d = 1'b0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rsp_valid) begin
          wb_valid_d = 1'b1;
          wb_err_d   = 1'b0;
          wb_rdata_d = wen_q ? 32'd0 : load_ext(f3_q, off_q, mem_rdata);
          state_d    = S_DONE;
        end
      end
      default: begin
        if (wb_ready) begin
          wb_valid_d = 1'b0;
          state_d    = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      wen_q       <= 1'b0;
      f3_q        <= 3'd0;
      off_q       <= 2'd0;
      req_valid_q <= 1'b0;
      mwen_q      <= 1'b0;
      maddr_q     <= 32'd0;
      mwdata_q    <= 32'd0;
      mwmask_q    <= 8'd0;
      wb_valid_q  <= 1'b0;
      wb_rdata_q  <= 32'd0;
      wb_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      wen_q       <= wen_d;
      f3_q        <= f3_d;
      off_q       <= off_d;
      req_valid_q <= req_valid_d;
      mwen_q      <= mwen_d;
      maddr_q     <= maddr_d;
      mwdata_q    <= mwdata_d;
      mwmask_q    <= mwmask_d;
      wb_valid_q  <= wb_valid_d;
      wb_rdata_q  <= wb_rdata_d;
      wb_err_q    <= wb_err_d;
    end
  end

  assign mem_req_valid = req_valid_q;
  assign mem_wen       = mwen_q;
  assign mem_addr      = maddr_q;
  assign mem_wdata     = mwdata_q;
  assign mem_wmask     = mwmask_q;
  assign wb_valid      = wb_valid_q;
  assign wb_rdata      = wb_rdata_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_ysyx_23060332_lsu.sv
module tb_ysyx_23060332_lsu;
  logic        clk = 1'b0;
  logic        rst;
  logic        lsu_valid, lsu_ready, lsu_wen;
  logic [2:0]  lsu_funct3;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        mem_req_valid, mem_req_ready, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [7:0]  mem_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rdata;
  logic        wb_valid, wb_ready, wb_err;
  logic [31:0] wb_rdata;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ysyx_23060332_lsu dut (
    .clk(clk), .rst(rst),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_wen(lsu_wen),
    .lsu_funct3(lsu_funct3), .lsu_addr(lsu_addr), .lsu_wdata(lsu_wdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_wen(mem_wen),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rdata(wb_rdata), .wb_err(wb_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Reference model: access size in bytes, or 0 for an illegal encoding.
  function automatic int ref_size(input bit wen, input logic [2:0] f3);
    if (wen) begin
      if (f3 == 3'd0) return 1;
      if (f3 == 3'd1) return 2;
      if (f3 == 3'd2) return 4;
      return 0;
    end
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit wen, input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(wen, f3);
    if (sz == 0) return 1'b0;
    return (a % sz) == 0;
  endfunction

  function automatic logic [31:0] ref_mask(input logic [2:0] f3, input logic [31:0] a);
    int sz = ref_size(1'b1, f3);
    int off = int'(a % 4);
    return ((32'd1 << sz) - 32'd1) << off;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [2:0] f3, input logic [31:0] w);
    int sz = ref_size(1'b1, f3);
    if (sz == 1) return (w & 32'hFF) * 32'h01010101;
    if (sz == 2) return (w & 32'hFFFF) * 32'h00010001;
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    int off = int'(a % 4);
    logic [31:0] b = (rd >> (8 * off)) & 32'hFF;
    logic [31:0] h = (rd >> (16 * (off / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b - 32'd256 : b;
      3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return rd;
    endcase
  endfunction

  // Write-back phase: hold wb_ready low dwb cycles (outputs must stay put), then handshake.
  task automatic wb_phase(input logic [31:0] exp_rd, input bit exp_err, input int dwb);
    for (int i = 0; i <= dwb; i++) begin
      check("wb_valid", wb_valid, 1);
      check("wb_rdata", wb_rdata, exp_rd);
      check("wb_err", wb_err, exp_err);
      check("mem_req_valid_done", mem_req_valid, 0);
      check("lsu_ready_done", lsu_ready, 0);
      wb_ready = (i == dwb);
      // A stray response while DONE must not disturb the held result.
      mem_rsp_valid = (i == 0);
      mem_rdata = $urandom;
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    wb_ready = 1'b0;
    check("wb_valid_after", wb_valid, 0);
    check("lsu_ready_after", lsu_ready, 1);
  endtask

  // One full transaction; called and returns at a negedge with the DUT idle.
  task automatic txn(input bit wen, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] w, input logic [31:0] rd,
                     input int dreq, input int drsp, input int dwb);
    bit ok = ref_legal(wen, f3, a);
    logic [31:0] e_mask = wen ? ref_mask(f3, a) : 32'd0;
    logic [31:0] e_wd = ref_wdata(f3, w);
    check("lsu_ready_idle", lsu_ready, 1);
    lsu_valid = 1'b1; lsu_wen = wen; lsu_funct3 = f3; lsu_addr = a; lsu_wdata = w;
    @(negedge clk);
    lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom;
    if (!ok) begin
      wb_phase(32'd0, 1'b1, dwb);
      return;
    end
    for (int i = 0; i <= dreq; i++) begin
      check("mem_req_valid", mem_req_valid, 1);
      check("mem_wen", mem_wen, wen);
      check("mem_addr", mem_addr, a - (a % 4));
      check("mem_wmask", mem_wmask, e_mask);
      if (wen) check("mem_wdata", mem_wdata, e_wd);
      check("wb_valid_req", wb_valid, 0);
      check("lsu_ready_req", lsu_ready, 0);
      mem_req_ready = (i == dreq);
      mem_rsp_valid = (i == 0 && dreq > 0);
      @(negedge clk);
      mem_rsp_valid = 1'b0;
    end
    mem_req_ready = 1'b0;
    for (int i = 0; i <= drsp; i++) begin
      check("mem_req_valid_wait", mem_req_valid, 0);
      check("wb_valid_wait", wb_valid, 0);
      mem_rsp_valid = (i == drsp);
      mem_rdata = (i == drsp) ? rd : $urandom;
      @(negedge clk);
    end
    mem_rsp_valid = 1'b0;
    wb_phase(wen ? 32'd0 : ref_load(f3, a, rd), 1'b0, dwb);
  endtask

  initial begin
    rst = 1'b1; lsu_valid = 0; lsu_wen = 0; lsu_funct3 = 0; lsu_addr = 0; lsu_wdata = 0;
    mem_req_ready = 0; mem_rsp_valid = 0; mem_rdata = 0; wb_ready = 0;
    repeat (2) @(negedge clk);
    check("rst_lsu_ready", lsu_ready, 0);
    check("rst_mem_req_valid", mem_req_valid, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wmask", mem_wmask, 0);
    check("rst_wb_valid", wb_valid, 0);
    check("rst_wb_rdata", wb_rdata, 0);
    check("rst_wb_err", wb_err, 0);
    rst = 1'b0;
    @(negedge clk);

    // Directed cases.
    txn(1, 3'd2, 32'h80000004, 32'hDEADBEEF, 0, 0, 0, 0);
    txn(1, 3'd0, 32'h80000003, 32'h000000A5, 0, 0, 0, 0);
    txn(1, 3'd1, 32'h80000002, 32'h00001234, 0, 0, 0, 0);
    txn(0, 3'd0, 32'h80000001, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd4, 32'h80000001, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd1, 32'h80000002, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd5, 32'h80000002, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd2, 32'h80000000, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd2, 32'h80000006, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd3, 32'h80000000, 0, 32'h8F34F678, 0, 0, 0);
    txn(0, 3'd2, 32'h80000008, 0, 32'h13572468, 3, 2, 2);

    // Reset while waiting for the response; the late response must be ignored.
    lsu_valid = 1; lsu_wen = 0; lsu_funct3 = 3'd2; lsu_addr = 32'h80000010;
    @(negedge clk);
    lsu_valid = 0; mem_req_ready = 1;
    @(negedge clk);
    mem_req_ready = 0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rstw_mem_req_valid", mem_req_valid, 0);
    check("rstw_wb_valid", wb_valid, 0);
    check("rstw_lsu_ready", lsu_ready, 0);
    check("rstw_mem_addr", mem_addr, 0);
    @(negedge clk);
    rst = 1'b0; mem_rsp_valid = 1; mem_rdata = 32'hCAFEF00D;
    @(negedge clk);
    mem_rsp_valid = 0;
    check("rstw_wb_valid_late", wb_valid, 0);
    check("rstw_wb_rdata_late", wb_rdata, 0);
    check("rstw_lsu_ready_late", lsu_ready, 1);
    txn(0, 3'd2, 32'h80000020, 0, 32'hA5A55A5A, 0, 1, 1);

    // Randomized transactions against the reference model.
    for (int n = 0; n < 80; n++) begin
      txn(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
          32'h80000000 | 32'($urandom_range(0, 63)), $urandom, $urandom,
          $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ysyx_23060332_lsu.md
# ysyx_23060332_lsu

Load/store unit: initiator side of the core's data-memory interface. It accepts one load or store at a time from the execute stage, then drives word-aligned address, shifted write data and byte mask to the data memory over a request/response handshake. For loads it extracts and sign- or zero-extends the result before handing it to write-back. It sits between the EXU and the DPI-backed data memory wrapper.

## Interface
- No parameters; address and data are fixed at 32 bits, mask at 8 bits (bits 7:4 always 0).
- clk  in  1  core clock, all state on rising edge
- rst  in  1  reset, asynchronous, active-high
- lsu_valid  in  1  EXU request valid
- lsu_ready  out  1  high only in IDLE with rst low
- lsu_wen  in  1  1 = store, 0 = load
- lsu_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW)
- lsu_addr  in  32  byte address
- lsu_wdata  in  32  store data, unshifted (rs2)
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_wen  out  1  request is a write
- mem_addr  out  32  lsu_addr with bits 1:0 cleared
- mem_wdata  out  32  store data shifted into byte lanes
- mem_wmask  out  8  byte-lane enables; 0 for loads
- mem_rsp_valid  in  1  response/ack, one cycle per request
- mem_rdata  in  32  read word, valid with mem_rsp_valid
- wb_valid  out  1  result valid to write-back
- wb_ready  in  1  write-back accepts result
- wb_rdata  out  32  extended load data; 0 for stores and errors
- wb_err  out  1  misaligned address or illegal funct3

## Operation
- States: IDLE, REQ, WAIT, DONE. All outputs are registered except lsu_ready.
- IDLE: on lsu_valid & lsu_ready, latch wen/funct3/addr/wdata. Legal and aligned: go to REQ. Otherwise: set wb_err=1, wb_rdata=0 and go to DONE with no memory access.
- Illegal encodings: loads with funct3 011/110/111; stores with funct3 not 000/001/010.
- Misalignment: halfword with addr[0]=1; word with addr[1:0]≠0.
- REQ: mem_req_valid=1 and memory fields stable until mem_req_ready is sampled high, then go to WAIT with mem_req_valid=0.
- WAIT: on mem_rsp_valid, go to DONE. Loads capture the result; stores set wb_rdata=0. A response in any other state is ignored.
- DONE: wb_valid=1 and wb outputs stable until wb_ready is sampled high, then go to IDLE.
- Store mask uses offset = addr[1:0]:
  - SB: 0x01<<offset, wdata = {4{wdata[7:0]}}.
  - SH: 0x03<<offset, wdata = {2{wdata[15:0]}}.
  - SW: 0x0F, wdata unchanged.
- Load extract from mem_rdata:
  - byte = rdata[8*offset+:8]; half = rdata[16*addr[1]+:16].
  - LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word through.

## Timing
- Reset (asynchronous): state IDLE. mem_req_valid, mem_wen, mem_addr, mem_wdata, mem_wmask, wb_valid, wb_rdata, wb_err are all 0. lsu_ready is 0 while rst is high.
- Best-case latency: accept at cycle 0 → REQ at 1 (ready high) → WAIT at 2 (rsp high) → wb_valid at cycle 3. Error path: wb_valid at cycle 1.
- Accept-to-accept throughput is at least 4 cycles. lsu_ready is low from the cycle after accept until the cycle after the wb handshake.
- mem_rsp_valid in the same cycle as the REQ handshake is not sampled; memory must respond no earlier than the next cycle.
- Stalls are unbounded; there is no timeout. All held outputs must not change while stalled.
- Reset in any state: immediate return to IDLE with mem_req_valid and wb_valid at 0. A late memory response is ignored.

## Test plan
- SW addr 0x80000004, wdata 0xDEADBEEF, ready and rsp immediate → mem_addr 0x80000004, mem_wmask 0x0F, mem_wdata 0xDEADBEEF, mem_wen 1; wb_valid at cycle 3 with wb_rdata 0, wb_err 0.
- SB addr 0x80000003, wdata 0x000000A5 → mem_addr 0x80000000, mem_wmask 0x08, mem_wdata 0xA5A5A5A5. SH addr 0x80000002 → mem_wmask 0x0C.
- Loads with mem_rdata 0x8F34F678:
  - LB @0x80000001 → 0xFFFFFFF6; LBU @0x80000001 → 0x000000F6.
  - LH @0x80000002 → 0xFFFF8F34; LHU @0x80000002 → 0x00008F34.
  - LW @0x80000000 → 0x8F34F678.
- LW @0x80000006 and load funct3=011 → mem_req_valid never asserts; wb_valid at cycle 1 with wb_err 1, wb_rdata 0.
- Backpressure: mem_req_ready low 3 cycles, rsp delayed 2 cycles, wb_ready low 2 cycles → mem fields and wb outputs stable throughout; exactly one memory request; lsu_ready low until after the wb handshake.
- Reset asserted in WAIT, then mem_rsp_valid after reset deasserts → outputs 0, response ignored, wb_valid stays 0; a following LW completes normally.
